duty_slew: RTL and testbench

Slew-rate limiter feeding the 10-bit unsigned duty input of the PWM stage. It accepts a new target duty via a one-cycle load strobe and walks its output toward that target by a programmable step size, at most once every STEP_DIV PWM periods. This gives soft-start and soft-stop for the driven load. The block keeps its own 1024-cycle period counter so that output changes are spaced at least one full PWM period apart. An emergency stop forces the output to zero immediately.

---
 rtl/duty_slew.sv | 122 ++++++++++++
 tb/tb_duty_slew.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_slew.sv
// duty_slew: slew-rate limiter for a PWM duty input. Walks set toward a loaded
// goal by step_eff on every step event (one per STEP_DIV periods of 2^WIDTH clocks).
module duty_slew #(
  parameter int WIDTH    = 10,
  parameter int STEP_DIV = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] target,
  input  logic             load,
  input  logic [3:0]       step,
  input  logic             stop,
  output logic [WIDTH-1:0] set,
  output logic             busy,
  output logic             done,
  output logic             period_tick
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] goal_q, goal_d;
  logic [WIDTH-1:0] set_q, set_d;
  state_t           state_q, state_d;
  logic             done_q, done_d;

  logic             tick;
  logic             step_evt;
  logic [3:0]       step_eff;
  logic [WIDTH-1:0] step_w;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   down_floor;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] down_val;
  logic             goal_above;
  logic             goal_below;

  // Free-running period counter and the period divider that paces step events.
  always_comb begin
    tick     = (cnt_q == {WIDTH{1'b1}});
    step_evt = tick && (div_q == DIV_LAST);
    cnt_d    = cnt_q + 1'b1;
    div_d    = div_q;
    if (tick) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // One extra bit keeps set+step from wrapping; the down path compares against
  // goal+step so the subtraction is only taken when it cannot pass the goal.
  always_comb begin
    step_eff   = (step == 4'd0) ? 4'd1 : step;
    step_w     = WIDTH'(step_eff);
    up_sum     = {1'b0, set_q} + {1'b0, step_w};
    down_floor = {1'b0, goal_q} + {1'b0, step_w};
    up_val     = (up_sum >= {1'b0, goal_q}) ? goal_q : up_sum[WIDTH-1:0];
    down_val   = ({1'b0, set_q} >= down_floor) ? (set_q - step_w) : goal_q;
    goal_above = (goal_q > set_q);
    goal_below = (goal_q < set_q);
  end

  always_comb begin
    goal_d  = goal_q;
    set_d   = set_q;
    state_d = IDLE;
    done_d  = 1'b0;
    if (stop) begin
      goal_d = '0;
      set_d  = '0;
    end else begin
      if (load) begin
        goal_d = target;
      end
      if (step_evt) begin
        if (goal_above) begin
          set_d = up_val;
        end else if (goal_below) begin
          set_d = down_val;
        end
      end
      if (goal_above) begin
        state_d = UP;
      end else if (goal_below) begin
        state_d = DOWN;
      end
      // A ramp just landed: the registered state still says UP/DOWN.
      done_d = (state_q != IDLE) && !goal_above && !goal_below;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      div_q   <= '0;
      goal_q  <= '0;
      set_q   <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      goal_q  <= goal_d;
      set_q   <= set_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign set         = set_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign period_tick = tick;

endmodule

// File: tb/tb_duty_slew.sv
// Bench for duty_slew: main instance (WIDTH=10, STEP_DIV=2) plus a narrow instance
// (WIDTH=4, STEP_DIV=1) for full-scale clamp cases; set changes are scoreboarded.
module tb_duty_slew;

  localparam int PER     = 1024;
  localparam int SD      = 2;
  localparam int SPACING = SD * PER;

  typedef struct {
    logic [9:0] val;
    bit         chk_gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] target;
  logic       load;
  logic [3:0] step;
  logic       stop;
  logic [9:0] set;
  logic       busy;
  logic       done;
  logic       period_tick;

  logic [3:0] s_target;
  logic       s_load;
  logic [3:0] s_step;
  logic       s_stop;
  logic [3:0] s_set;
  logic       s_busy;
  logic       s_done;
  logic       s_tick;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_chg = 0;
  int done_cnt = 0;
  int s_done_cnt = 0;
  logic [9:0] prev_set = '0;
  logic [3:0] s_prev_set = '0;
  exp_t exp_q[$];
  logic [3:0] s_exp_q[$];
  exp_t mon_e;
  logic [3:0] s_mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  duty_slew #(.WIDTH(10), .STEP_DIV(SD)) dut (
    .clk(clk), .reset_n(reset_n), .target(target), .load(load), .step(step),
    .stop(stop), .set(set), .busy(busy), .done(done), .period_tick(period_tick)
  );

  duty_slew #(.WIDTH(4), .STEP_DIV(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .target(s_target), .load(s_load), .step(s_step),
    .stop(s_stop), .set(s_set), .busy(s_busy), .done(s_done), .period_tick(s_tick)
  );

  // Scoreboard for the main instance: every set change must match the queue head.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_set = set;
    end else begin
      if (set !== prev_set) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL set_change: got set=%0d, required unchanged %0d (cycle %0d)", set, prev_set, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (set !== mon_e.val)
            $display("FAIL set_value: got %0d, required %0d (cycle %0d)", set, mon_e.val, cyc);
          else
            passes++;
          if (mon_e.chk_gap) begin
            checks++;
            if (cyc - last_chg != SPACING)
              $display("FAIL set_spacing: got %0d clocks, required %0d", cyc - last_chg, SPACING);
            else
              passes++;
          end
        end
        $display("set %0d -> %0d at cycle %0d", prev_set, set, cyc);
        last_chg = cyc;
        prev_set = set;
      end
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (busy !== 1'b0 || cyc != last_chg + 1)
          $display("FAIL done_timing: busy=%0d cycle=%0d, required busy=0 cycle=%0d", busy, cyc, last_chg + 1);
        else
          passes++;
        $display("done at cycle %0d", cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      s_prev_set = s_set;
    end else begin
      if (s_set !== s_prev_set) begin
        checks++;
        if (s_exp_q.size() == 0) begin
          $display("FAIL s_set_change: got %0d, required unchanged %0d", s_set, s_prev_set);
        end else begin
          s_mon_e = s_exp_q.pop_front();
          if (s_set !== s_mon_e)
            $display("FAIL s_set_value: got %0d, required %0d", s_set, s_mon_e);
          else
            passes++;
        end
        $display("narrow set %0d -> %0d at cycle %0d", s_prev_set, s_set, cyc);
        s_prev_set = s_set;
      end
      if (s_done === 1'b1) begin
        s_done_cnt++;
        checks++;
        if (s_busy !== 1'b0)
          $display("FAIL s_done_busy: got busy=%0d, required 0", s_busy);
        else
          passes++;
      end
    end
  end

  task automatic drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic s_drain(input int limit);
    for (int i = 0; i < limit && s_exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic push(input logic [9:0] v, input bit g);
    exp_t e;
    e.val = v;
    e.chk_gap = g;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [9:0] t, input logic [3:0] s);
    target = t;
    step = s;
    load = 1'b1;
    $display("load target=%0d step=%0d at cycle %0d", t, s, cyc);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    int rel;
    int t_prev;
    reset_n = 1'b1;
    target = '0; load = 1'b0; step = '0; stop = 1'b0;
    s_target = '0; s_load = 1'b0; s_step = '0; s_stop = 1'b0;
    #1 reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({set, busy, done, period_tick} !== 13'd0)
      $display("FAIL reset_main: got set=%0d busy=%0d done=%0d tick=%0d, required all 0", set, busy, done, period_tick);
    else
      passes++;
    checks++;
    if ({s_set, s_busy, s_done, s_tick} !== 7'd0)
      $display("FAIL reset_narrow: got set=%0d busy=%0d done=%0d tick=%0d, required all 0", s_set, s_busy, s_done, s_tick);
    else
      passes++;
    reset_n = 1'b1;
    rel = cyc;
    for (int i = 0; i < PER + 50 && period_tick !== 1'b1; i++) @(negedge clk);
    checks++;
    if (cyc - rel != PER - 1)
      $display("FAIL first_tick: got %0d clocks after release, required %0d", cyc - rel, PER - 1);
    else
      passes++;
    t_prev = cyc;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (period_tick !== 1'b0)
        $display("FAIL tick_width: got tick=%0d one clock later, required 0", period_tick);
      else
        passes++;
      for (int i = 0; i < PER + 50 && period_tick !== 1'b1; i++) @(negedge clk);
      checks++;
      if (cyc - t_prev != PER)
        $display("FAIL tick_period: got %0d clocks, required %0d", cyc - t_prev, PER);
      else
        passes++;
      t_prev = cyc;
    end
  endtask

  task automatic test_ramp_up();
    int d0;
    d0 = done_cnt;
    push(10'd10, 1'b0);
    for (int v = 20; v <= 100; v += 10) push(10'(v), 1'b1);
    do_load(10'd100, 4'd10);
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_latency_early: got %0d, required 0", busy); else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_latency_rise: got %0d, required 1", busy); else passes++;
    drain(11 * SPACING);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL ramp_up_steps: got %0d steps missing, required 0", exp_q.size()); else passes++;
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || set !== 10'd100)
      $display("FAIL ramp_up_end: got done=%0d busy=%0d set=%0d, required 1 0 100", done_cnt - d0, busy, set);
    else
      passes++;
  endtask

  task automatic test_clamp_down();
    int d0;
    d0 = done_cnt;
    push(10'd85, 1'b0);
    push(10'd70, 1'b1); push(10'd55, 1'b1); push(10'd40, 1'b1);
    push(10'd25, 1'b1); push(10'd10, 1'b1); push(10'd5, 1'b1);
    do_load(10'd5, 4'd15);
    drain(8 * SPACING);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1 || busy !== 1'b0 || set !== 10'd5)
      $display("FAIL clamp_down_end: got left=%0d done=%0d busy=%0d set=%0d, required 0 1 0 5", exp_q.size(), done_cnt - d0, busy, set);
    else
      passes++;
  endtask

  task automatic test_stop();
    int d0;
    push(10'd20, 1'b0);
    do_load(10'd1023, 4'd15);
    drain(2 * SPACING);
    checks++;
    if (busy !== 1'b1 || set !== 10'd20)
      $display("FAIL stop_pre: got busy=%0d set=%0d, required 1 20", busy, set);
    else
      passes++;
    d0 = done_cnt;
    push(10'd0, 1'b0);
    stop = 1'b1;
    target = 10'd300;
    load = 1'b1;
    $display("stop with load target=300 at cycle %0d", cyc);
    @(negedge clk);
    stop = 1'b0;
    load = 1'b0;
    checks++;
    if (set !== 10'd0 || busy !== 1'b0)
      $display("FAIL stop_edge: got set=%0d busy=%0d, required 0 0", set, busy);
    else
      passes++;
    repeat (SPACING + 16) @(negedge clk);
    checks++;
    if (set !== 10'd0 || busy !== 1'b0 || done_cnt != d0)
      $display("FAIL stop_hold: got set=%0d busy=%0d done=%0d, required 0 0 0", set, busy, done_cnt - d0);
    else
      passes++;
  endtask

  task automatic test_retarget();
    int d0;
    d0 = done_cnt;
    push(10'd8, 1'b0);
    for (int v = 16; v <= 40; v += 8) push(10'(v), 1'b1);
    do_load(10'd1023, 4'd8);
    drain(6 * SPACING);
    checks++;
    if (set !== 10'd40 || busy !== 1'b1)
      $display("FAIL retarget_pre: got set=%0d busy=%0d, required 40 1", set, busy);
    else
      passes++;
    push(10'd32, 1'b1); push(10'd24, 1'b1); push(10'd16, 1'b1);
    do_load(10'd16, 4'd8);
    drain(4 * SPACING);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1 || busy !== 1'b0 || set !== 10'd16)
      $display("FAIL retarget_end: got left=%0d done=%0d busy=%0d set=%0d, required 0 1 0 16", exp_q.size(), done_cnt - d0, busy, set);
    else
      passes++;
  endtask

  task automatic test_step_zero();
    int d0;
    d0 = done_cnt;
    push(10'd17, 1'b0);
    push(10'd18, 1'b1);
    do_load(10'd18, 4'd0);
    drain(3 * SPACING);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1 || set !== 10'd18)
      $display("FAIL step_zero: got left=%0d done=%0d set=%0d, required 0 1 18", exp_q.size(), done_cnt - d0, set);
    else
      passes++;
  endtask

  task automatic test_same_target();
    int d0;
    bit busy_seen;
    d0 = done_cnt;
    busy_seen = 1'b0;
    do_load(10'd18, 4'd5);
    for (int i = 0; i < SPACING + 16; i++) begin
      if (busy !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (busy_seen || done_cnt != d0 || set !== 10'd18)
      $display("FAIL same_target: got busy_seen=%0d done=%0d set=%0d, required 0 0 18", busy_seen, done_cnt - d0, set);
    else
      passes++;
  endtask

  task automatic test_full_scale();
    int d0;
    d0 = s_done_cnt;
    s_exp_q.push_back(4'd7); s_exp_q.push_back(4'd14); s_exp_q.push_back(4'd15);
    s_target = 4'd15; s_step = 4'd7; s_load = 1'b1;
    $display("narrow load target=15 step=7 at cycle %0d", cyc);
    @(negedge clk);
    s_load = 1'b0;
    s_drain(100);
    repeat (4) @(negedge clk);
    checks++;
    if (s_exp_q.size() != 0 || s_done_cnt - d0 != 1 || s_set !== 4'd15)
      $display("FAIL full_scale_up: got left=%0d done=%0d set=%0d, required 0 1 15", s_exp_q.size(), s_done_cnt - d0, s_set);
    else
      passes++;
    d0 = s_done_cnt;
    s_exp_q.push_back(4'd8); s_exp_q.push_back(4'd1); s_exp_q.push_back(4'd0);
    s_target = 4'd0; s_load = 1'b1;
    $display("narrow load target=0 step=7 at cycle %0d", cyc);
    @(negedge clk);
    s_load = 1'b0;
    s_drain(100);
    repeat (4) @(negedge clk);
    checks++;
    if (s_exp_q.size() != 0 || s_done_cnt - d0 != 1 || s_set !== 4'd0)
      $display("FAIL full_scale_down: got left=%0d done=%0d set=%0d, required 0 1 0", s_exp_q.size(), s_done_cnt - d0, s_set);
    else
      passes++;
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_ramp_up();
    test_clamp_down();
    test_stop();
    test_retarget();
    test_step_zero();
    test_same_target();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation exceeded 200000 clocks, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
